// File: rtl/regfile_2r1w.sv
// Register file: one write port and two independent read ports. Each read returns
// registered data one cycle after its request, with write-first bypass on collisions.
module regfile_2r1w #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ra_req,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_valid,
  input  logic              rb_req,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_en;

  logic [1:0]             w_req;
  logic [ADDR_W-1:0]      w_addr   [2];
  logic [DATA_W-1:0]      w_rdata  [2];
  logic [DATA_W-1:0]      r_data   [2];
  logic [1:0]             r_valid;
  logic                   r_busy;

  // Writes to register 0 are discarded when it is hard-wired to zero.
  assign w_wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign w_req[0]  = ra_req;
  assign w_req[1]  = rb_req;
  assign w_addr[0] = ra_addr;
  assign w_addr[1] = rb_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      // Zero register wins over the bypass; otherwise a same-edge write is returned.
      always_comb begin
        w_rdata[gi] = r_mem[w_addr[gi]];
        if ((ZERO_REG != 0) && (w_addr[gi] == '0)) begin
          w_rdata[gi] = '0;
        end else if (we && (waddr == w_addr[gi])) begin
          w_rdata[gi] = wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data[gi]  <= '0;
          r_valid[gi] <= 1'b0;
        end else begin
          r_valid[gi] <= w_req[gi];
          if (w_req[gi]) begin
            r_data[gi] <= w_rdata[gi];
          end
        end
      end
    end
  endgenerate

  // Registered copy of the OR of both valids, so it tracks them without an input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= ra_req | rb_req;
    end
  end

  assign ra_data  = r_data[0];
  assign rb_data  = r_data[1];
  assign ra_valid = r_valid[0];
  assign rb_valid = r_valid[1];
  assign rd_busy  = r_busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed table-driven bench for regfile_2r1w, plus a hand-written async-reset sequence.
module tb_regfile_2r1w;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       ra_req;
  logic [2:0] ra_addr;
  logic [7:0] ra_data;
  logic       ra_valid;
  logic       rb_req;
  logic [2:0] rb_addr;
  logic [7:0] rb_data;
  logic       rb_valid;
  logic       rd_busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .we(we), .waddr(waddr), .wdata(wdata),
    .ra_req(ra_req), .ra_addr(ra_addr), .ra_data(ra_data), .ra_valid(ra_valid),
    .rb_req(rb_req), .rb_addr(rb_addr), .rb_data(rb_data), .rb_valid(rb_valid),
    .rd_busy(rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       ra_req;
    logic [2:0] ra_addr;
    logic       rb_req;
    logic [2:0] rb_addr;
    logic       chk_a;
    logic [7:0] exp_a;
    logic       chk_b;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic we_i, logic [2:0] wa, logic [7:0] wd,
                              logic rq_a, logic [2:0] aa, logic rq_b, logic [2:0] ab,
                              logic ca, logic [7:0] ea, logic cb, logic [7:0] eb);
    vec_t v;
    v.name = name; v.we = we_i; v.waddr = wa; v.wdata = wd;
    v.ra_req = rq_a; v.ra_addr = aa; v.rb_req = rq_b; v.rb_addr = ab;
    v.chk_a = ca; v.exp_a = ea; v.chk_b = cb; v.exp_b = eb;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("[TB] ok %s: 0x%02h", name, act);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    ra_req = 1'b0; ra_addr = '0; rb_req = 1'b0; rb_addr = '0;

    // Reset state
    #12;
    check("rst_ra_data", ra_data, 8'h00);
    check("rst_rb_data", rb_data, 8'h00);
    check("rst_valids", {6'b0, ra_valid, rb_valid}, 8'h00);
    check("rst_busy", {7'b0, rd_busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Request, then assert reset mid-cycle: valids must drop with no clock edge.
    @(negedge clk);
    ra_req = 1'b1; ra_addr = 3'd1; rb_req = 1'b1; rb_addr = 3'd2;
    @(posedge clk); #1;
    check("pre_rst_ra_valid", {7'b0, ra_valid}, 8'h01);
    check("pre_rst_busy", {7'b0, rd_busy}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ra_valid", {7'b0, ra_valid}, 8'h00);
    check("async_rst_rb_valid", {7'b0, rb_valid}, 8'h00);
    check("async_rst_busy", {7'b0, rd_busy}, 8'h00);
    @(negedge clk);
    ra_req = 1'b0; rb_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rel_no_valid", {6'b0, ra_valid, rb_valid}, 8'h00);

    // Directed vector table
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("rd_after_rst_%0d", i), 0, 0, 0,
                        1, 3'(i), 1, 3'(7 - i), 1, 8'h00, 1, 8'h00));
    vecs.push_back(mk("wr_a5_addr3", 1, 3, 8'hA5, 0, 0, 0, 0, 1, 8'h00, 1, 8'h00));
    vecs.push_back(mk("rd_addr3", 0, 0, 0, 1, 3, 0, 0, 1, 8'hA5, 1, 8'h00));
    vecs.push_back(mk("idle_hold", 0, 0, 0, 0, 0, 0, 0, 1, 8'hA5, 1, 8'h00));
    vecs.push_back(mk("bypass_addr5", 1, 5, 8'h3C, 1, 5, 1, 5, 1, 8'h3C, 1, 8'h3C));
    vecs.push_back(mk("zero_wr_bypass", 1, 0, 8'hFF, 1, 5, 1, 0, 1, 8'h3C, 1, 8'h00));
    vecs.push_back(mk("zero_rd_later", 0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 1, 8'h00));
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk($sformatf("stream_%0d", i), 1, 3'(i), 8'(i * 8'h11),
                        1, 3'(i - 1), 1, 3'(i), 1, 8'((i - 1) * 8'h11), 1, 8'(i * 8'h11)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk($sformatf("hold_we0_%0d", i), 0, 2, 8'h77,
                        1, 2, 1, 2, 1, 8'h22, 1, 8'h22));
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk($sformatf("scan_%0d", i), 0, 0, 0,
                        1, 3'(i), 1, 0, 1, 8'(i * 8'h11), 1, 8'h00));

    foreach (vecs[k]) begin
      @(negedge clk);
      we = vecs[k].we; waddr = vecs[k].waddr; wdata = vecs[k].wdata;
      ra_req = vecs[k].ra_req; ra_addr = vecs[k].ra_addr;
      rb_req = vecs[k].rb_req; rb_addr = vecs[k].rb_addr;
      @(posedge clk); #1;
      check({vecs[k].name, "_ra_valid"}, {7'b0, ra_valid}, {7'b0, vecs[k].ra_req});
      check({vecs[k].name, "_rb_valid"}, {7'b0, rb_valid}, {7'b0, vecs[k].rb_req});
      check({vecs[k].name, "_busy"}, {7'b0, rd_busy},
            {7'b0, vecs[k].ra_req | vecs[k].rb_req});
      if (vecs[k].chk_a) check({vecs[k].name, "_ra_data"}, ra_data, vecs[k].exp_a);
      if (vecs[k].chk_b) check({vecs[k].name, "_rb_data"}, rb_data, vecs[k].exp_b);
    end

    // Single request: valid must be a one-cycle pulse.
    @(negedge clk);
    we = 1'b0; ra_req = 1'b1; ra_addr = 3'd4; rb_req = 1'b0;
    @(negedge clk);
    ra_req = 1'b0;
    check("pulse_ra_valid_hi", {7'b0, ra_valid}, 8'h01);
    check("pulse_ra_data", ra_data, 8'h44);
    @(negedge clk);
    check("pulse_ra_valid_lo", {7'b0, ra_valid}, 8'h00);
    check("pulse_busy_lo", {7'b0, rd_busy}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
